// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side responder: decodes read/write frames for PHY_ADDR and
// serves a 32 x 16-bit register file through a tristate MDIO pad.
`timescale 1ns/1ps
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          PRE_LEN      = 32,
  parameter logic [15:0] REG0_DEFAULT = 16'h1140,
  parameter logic [15:0] STATUS_BASE  = 16'h7949,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        link_up,
  output logic        soft_rst,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
  } state_t;

  localparam logic [5:0] PRE_MAX = 6'(PRE_LEN);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  pre_q, pre_d;

  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev;
  logic        mdc_rise, mdc_fall, bit_in;

  logic [15:0] sh_q;
  logic        is_rd_q;
  logic        phy_ok_q;
  logic [4:0]  regad_q;
  logic [14:0] reg0_q;
  logic [15:0] regs [4:31];

  logic        op_last, phy_last, reg_last, wr_last, shift_en;
  logic        ta_drive, rd_fall;
  logic [4:0]  field;
  logic [15:0] wr_word, rd_word;

  // Idle level of both lines is high, so the synchronisers reset to 1 and
  // leaving reset never fakes an mdc edge while the bus is quiet.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every flop sees pre-edge values.
    if (rst) begin
      mdc_sync  <= 2'b11;
      mdio_sync <= 2'b11;
      mdc_prev  <= 1'b1;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdio_sync <= {mdio_sync[0], mdio_i};
      mdc_prev  <= mdc_sync[1];
    end
  end

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign mdc_fall = ~mdc_sync[1] & mdc_prev;
  assign bit_in   = mdio_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (bit_in) begin
            pre_d = (pre_q == PRE_MAX) ? pre_q : pre_q + 6'd1;
          end else begin
            if (pre_q == PRE_MAX) state_d = S_ST2;
            pre_d = '0;
          end
        end
        S_ST2: begin
          state_d = bit_in ? S_OP : S_IDLE;
          cnt_d   = '0;
        end
        S_OP: begin
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else if (sh_q[0] != bit_in) begin
            state_d = S_PHYAD;
            cnt_d   = '0;
          end else begin
            // Bad opcode: PHYAD, REGAD, TA and DATA still to pass (28 bits).
            state_d = S_SKIP;
            cnt_d   = 5'd27;
          end
        end
        S_PHYAD: begin
          if (cnt_q == 5'd4) begin
            state_d = S_REGAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          if (cnt_q == 5'd4) begin
            state_d = phy_ok_q ? S_TA : S_SKIP;
            cnt_d   = phy_ok_q ? 5'd0 : 5'd17;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_TA: begin
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          if (!is_rd_q) begin
            if (cnt_q == 5'd15) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
        S_SKIP: begin
          if (cnt_q == 5'd0) state_d = S_IDLE;
          else               cnt_d   = cnt_q - 5'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (rd_fall) begin
      // Read data is paced by falling edges: 16 drive edges, then one release edge.
      if (cnt_q == 5'd16) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  assign op_last  = mdc_rise && (state_q == S_OP)    && (cnt_q == 5'd1);
  assign phy_last = mdc_rise && (state_q == S_PHYAD) && (cnt_q == 5'd4);
  assign reg_last = mdc_rise && (state_q == S_REGAD) && (cnt_q == 5'd4);
  assign wr_last  = mdc_rise && (state_q == S_DATA) && !is_rd_q && (cnt_q == 5'd15);
  assign shift_en = mdc_rise && ((state_q inside {S_OP, S_PHYAD, S_REGAD}) ||
                                 ((state_q == S_DATA) && !is_rd_q));
  assign ta_drive = mdc_fall && (state_q == S_TA) && is_rd_q && (cnt_q == 5'd1);
  assign rd_fall  = mdc_fall && (state_q == S_DATA) && is_rd_q;
  assign field    = {sh_q[3:0], bit_in};
  assign wr_word  = {sh_q[14:0], bit_in};

  always_comb begin
    rd_word = '0;
    case (field)
      5'd0:    rd_word = {1'b0, reg0_q};
      5'd1:    rd_word = {STATUS_BASE[15:3], link_up, STATUS_BASE[1:0]};
      5'd2:    rd_word = PHY_ID1;
      5'd3:    rd_word = PHY_ID2;
      default: rd_word = regs[field];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      is_rd_q  <= 1'b0;
      phy_ok_q <= 1'b0;
      regad_q  <= '0;
      mdio_o   <= 1'b0;
      mdio_t   <= 1'b1;
      soft_rst <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      reg0_q   <= REG0_DEFAULT[14:0];
      // NOTE: the register file is reset explicitly because registers 4..31 must read 0 after reset.
      for (int i = 4; i < 32; i++) regs[i] <= '0;
    end else begin
      soft_rst <= 1'b0;
      wr_valid <= 1'b0;

      if (shift_en) sh_q     <= {sh_q[14:0], bit_in};
      if (op_last)  is_rd_q  <= sh_q[0];
      if (phy_last) phy_ok_q <= (field == PHY_ADDR);
      if (reg_last) begin
        regad_q <= field;
        if (is_rd_q) sh_q <= rd_word;
      end

      // Pad outputs change only in the cycle after a falling mdc edge.
      if (ta_drive) begin
        mdio_t <= 1'b0;
        mdio_o <= 1'b0;
      end
      if (rd_fall) begin
        if (cnt_q == 5'd16) begin
          mdio_t <= 1'b1;
          mdio_o <= 1'b0;
        end else begin
          mdio_o <= sh_q[15];
          sh_q   <= {sh_q[14:0], 1'b0};
        end
      end

      // Registers 1..3 are read-only: such writes vanish without a commit pulse.
      if (wr_last && !(regad_q inside {[5'd1:5'd3]})) begin
        wr_valid <= 1'b1;
        wr_addr  <= regad_q;
        wr_data  <= wr_word;
        if (regad_q == 5'd0) begin
          if (wr_word[15]) begin
            soft_rst <= 1'b1;
            reg0_q   <= REG0_DEFAULT[14:0];
            for (int i = 4; i < 32; i++) regs[i] <= '0;
          end else begin
            reg0_q <= wr_word[14:0];
          end
        end else begin
          regs[regad_q] <= wr_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: a bit-banged MDIO master plays a vector
// table of frames, then hand-written soft-reset, link status and mid-frame reset cases.
`timescale 1ns/1ps
module tb_mdio_phy_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b1;
  logic        m_drv = 1'b1;
  logic        link_up = 1'b0;
  logic        mdio_i, mdio_o, mdio_t, soft_rst, wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int   checks = 0;
  int   errors = 0;
  int   wv_cnt = 0, sr_cnt = 0, wv_soft = 0, wv_wide = 0, drove_cnt = 0;
  logic wv_prev = 1'b0;

  always #5 clk = ~clk;

  // Shared line: pulled high by the master side unless the responder drives it.
  assign mdio_i = mdio_t ? m_drv : mdio_o;

  mdio_phy_responder dut (
    .clk      (clk),
    .rst      (rst),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdio_o   (mdio_o),
    .mdio_t   (mdio_t),
    .link_up  (link_up),
    .soft_rst (soft_rst),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt++;
      if (soft_rst) wv_soft++;
      if (wv_prev)  wv_wide++;
    end
    if (soft_rst) sr_cnt++;
    if (!mdio_t)  drove_cnt++;
    wv_prev = wr_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One bit time: falling edge, master drives b, sample pad just before rising.
  task automatic bit_cycle(input logic b, output logic pad, output logic t);
    mdc = 1'b0; m_drv = b;
    #45; pad = mdio_i; t = mdio_t;
    #5;  mdc = 1'b1;
    #50;
  endtask

  task automatic send_bit(input logic b);
    logic p, t;
    bit_cycle(b, p, t);
  endtask

  // Closing falling edge with the line released; mdc then rests low.
  task automatic tail(output logic t);
    mdc = 1'b0; m_drv = 1'b1;
    #45; t = mdio_t;
    #5;
  endtask

  task automatic send_header(input logic rd, input int pre, input logic [4:0] phy, input logic [4:0] ra);
    for (int i = 0; i < pre; i++) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    send_bit(rd);   send_bit(!rd);
    for (int i = 4; i >= 0; i--) send_bit(phy[i]);
    for (int i = 4; i >= 0; i--) send_bit(ra[i]);
  endtask

  task automatic read_body(output logic ta1_t, output logic [1:0] ta2, output logic [15:0] rdata,
                           output logic rel_t);
    logic p, t;
    bit_cycle(1'b1, p, t); ta1_t = t;
    bit_cycle(1'b1, p, t); ta2 = {t, p};
    rdata = '0;
    for (int i = 0; i < 16; i++) begin
      bit_cycle(1'b1, p, t);
      rdata = {rdata[14:0], p};
    end
    tail(rel_t);
  endtask

  task automatic write_body(input logic [15:0] wd);
    logic t;
    send_bit(1'b1); send_bit(1'b0);
    for (int i = 15; i >= 0; i--) send_bit(wd[i]);
    tail(t);
  endtask

  task automatic do_read(input string name, input logic [4:0] ra, input logic [15:0] req);
    logic ta1, rel;
    logic [1:0]  ta2;
    logic [15:0] rd;
    send_header(1'b1, 32, 5'd1, ra);
    read_body(ta1, ta2, rd, rel);
    check({name, " ta2"}, 32'(ta2), 32'd0);
    check({name, " data"}, 32'(rd), 32'(req));
    check({name, " release"}, 32'(rel), 32'd1);
  endtask

  typedef struct {
    logic        wr;
    int          pre;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] data;   // write data, or expected read data
    logic        drive;  // responder expected to drive the line
    int          wv;     // expected wr_valid pulses
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  initial begin
    logic        ta1, rel, t, p;
    logic [1:0]  ta2;
    logic [15:0] rd;
    int          wv0, sr0, ws0, dr0;

    vecs[0]  = '{1'b0, 32, 5'd1, 5'd2,  16'h0141, 1'b1, 0};
    vecs[1]  = '{1'b1, 32, 5'd1, 5'd4,  16'hA5A5, 1'b0, 1};
    vecs[2]  = '{1'b0, 32, 5'd1, 5'd4,  16'hA5A5, 1'b1, 0};
    vecs[3]  = '{1'b0, 32, 5'd3, 5'd4,  16'hFFFF, 1'b0, 0};
    vecs[4]  = '{1'b0, 32, 5'd1, 5'd3,  16'h0CC2, 1'b1, 0};
    vecs[5]  = '{1'b1, 31, 5'd1, 5'd5,  16'hBEEF, 1'b0, 0};
    vecs[6]  = '{1'b0, 32, 5'd1, 5'd5,  16'h0000, 1'b1, 0};
    vecs[7]  = '{1'b1, 32, 5'd1, 5'd5,  16'h1234, 1'b0, 1};
    vecs[8]  = '{1'b0, 32, 5'd1, 5'd5,  16'h1234, 1'b1, 0};
    vecs[9]  = '{1'b0, 32, 5'd1, 5'd0,  16'h1140, 1'b1, 0};
    vecs[10] = '{1'b1, 32, 5'd1, 5'd0,  16'h0100, 1'b0, 1};
    vecs[11] = '{1'b0, 32, 5'd1, 5'd0,  16'h0100, 1'b1, 0};
    vecs[12] = '{1'b1, 32, 5'd1, 5'd2,  16'hFFFF, 1'b0, 0};
    vecs[13] = '{1'b0, 32, 5'd1, 5'd2,  16'h0141, 1'b1, 0};
    vecs[14] = '{1'b1, 32, 5'd2, 5'd6,  16'h5555, 1'b0, 0};
    vecs[15] = '{1'b0, 32, 5'd1, 5'd6,  16'h0000, 1'b1, 0};
    vecs[16] = '{1'b1, 32, 5'd1, 5'd31, 16'h8001, 1'b0, 1};
    vecs[17] = '{1'b0, 32, 5'd1, 5'd31, 16'h8001, 1'b1, 0};

    #95;
    check("reset mdio_t",   32'(mdio_t),   32'd1);
    check("reset mdio_o",   32'(mdio_o),   32'd0);
    check("reset soft_rst", 32'(soft_rst), 32'd0);
    check("reset wr_valid", 32'(wr_valid), 32'd0);
    check("reset wr_addr",  32'(wr_addr),  32'd0);
    check("reset wr_data",  32'(wr_data),  32'd0);
    #5 rst = 1'b0;
    #100;

    for (int i = 0; i < NVEC; i++) begin
      wv0 = wv_cnt;
      dr0 = drove_cnt;
      send_header(!vecs[i].wr, vecs[i].pre, vecs[i].phy, vecs[i].ra);
      if (vecs[i].wr) begin
        write_body(vecs[i].data);
        if (vecs[i].wv != 0) begin
          check($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].ra));
          check($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vecs[i].data));
        end
      end else begin
        read_body(ta1, ta2, rd, rel);
        check($sformatf("vec%0d ta1 mdio_t", i), 32'(ta1), 32'd1);
        check($sformatf("vec%0d ta2 {t,pad}", i), 32'(ta2), vecs[i].drive ? 32'd0 : 32'd3);
        check($sformatf("vec%0d rdata", i), 32'(rd), 32'(vecs[i].data));
        check($sformatf("vec%0d release", i), 32'(rel), 32'd1);
      end
      check($sformatf("vec%0d drove", i), 32'(drove_cnt != dr0), 32'(vecs[i].drive));
      check($sformatf("vec%0d wr_valid count", i), 32'(wv_cnt - wv0), 32'(vecs[i].wv));
    end

    // Soft reset via register 0 bit 15.
    wv0 = wv_cnt; sr0 = sr_cnt; ws0 = wv_soft;
    send_header(1'b0, 32, 5'd1, 5'd0);
    write_body(16'h8000);
    check("softrst wr_valid count", 32'(wv_cnt - wv0), 32'd1);
    check("softrst soft_rst count", 32'(sr_cnt - sr0), 32'd1);
    check("softrst coincident",     32'(wv_soft - ws0), 32'd1);
    check("softrst wr_addr",        32'(wr_addr), 32'd0);
    check("softrst wr_data",        32'(wr_data), 32'h8000);
    do_read("softrst reg0",  5'd0,  16'h1140);
    do_read("softrst reg5",  5'd5,  16'h0000);
    do_read("softrst reg4",  5'd4,  16'h0000);
    do_read("softrst reg31", 5'd31, 16'h0000);

    link_up = 1'b0;
    do_read("reg1 link down", 5'd1, 16'h7949);
    link_up = 1'b1;
    do_read("reg1 link up",   5'd1, 16'h794D);

    // Reset while data bit 5 of a read of register 3 is on the line.
    wv0 = wv_cnt;
    send_header(1'b1, 32, 5'd1, 5'd3);
    bit_cycle(1'b1, p, t);
    bit_cycle(1'b1, p, t);
    for (int i = 15; i > 5; i--) bit_cycle(1'b1, p, t);
    mdc = 1'b0; m_drv = 1'b1;
    #40;
    check("midrst driving before rst", 32'(mdio_t), 32'd0);
    rst = 1'b1;
    #10;
    check("midrst mdio_t next cycle", 32'(mdio_t), 32'd1);
    check("midrst mdio_o",            32'(mdio_o), 32'd0);
    check("midrst wr_data",           32'(wr_data), 32'd0);
    rst = 1'b0;
    mdc = 1'b1;
    #50;
    dr0 = drove_cnt;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    tail(t);
    check("midrst residual drive", 32'(drove_cnt - dr0), 32'd0);
    check("midrst no commit",      32'(wv_cnt - wv0), 32'd0);
    do_read("midrst reg3", 5'd3, 16'h0CC2);
    do_read("midrst reg0", 5'd0, 16'h1140);

    check("wr_valid single-cycle", 32'(wv_wide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
